// File: rtl/mem_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and load/store.
// One transaction in flight; data has priority, with a streak limit that protects fetch.
module mem_arbiter #(
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_size,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        dbg_state,
    output logic [3:0]  dbg_streak
);
    // Handshake: a requester holds req and its payload until the cycle its gnt is 1;
    // that cycle is acceptance. Its rvalid follows exactly LATENCY cycles later, for one cycle.
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_t;

    localparam logic [3:0] LAT4    = 4'(LATENCY);
    localparam logic [3:0] STARVE4 = 4'(STARVE_LIMIT);

    state_t     r_state, w_state_nxt;
    owner_t     r_owner, w_owner_nxt;
    logic       r_is_store, w_is_store_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_streak, w_streak_nxt;

    logic w_resp, w_slot, w_pick_d, w_pick_f;

    assign w_resp   = (r_state == BUSY) && (r_cnt == 4'd1);
    assign w_slot   = !rst && ((r_state == IDLE) || w_resp);
    // Fetch only overrides a simultaneous data request once the data streak hits the limit.
    assign w_pick_d = w_slot && d_req && (!if_req || (r_streak != STARVE4));
    assign w_pick_f = w_slot && if_req && !w_pick_d;

    assign busy       = (r_state == BUSY);
    assign dbg_state  = r_state;
    assign dbg_streak = r_streak;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_FETCH;
            r_is_store <= 1'b0;
            r_cnt      <= 4'd0;
            r_streak   <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_is_store <= w_is_store_nxt;
            r_cnt      <= w_cnt_nxt;
            r_streak   <= w_streak_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_is_store_nxt = r_is_store;
        w_cnt_nxt      = r_cnt;
        w_streak_nxt   = r_streak;
        if_gnt         = w_pick_f;
        d_gnt          = w_pick_d;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 32'd0;
        mem_wdata      = 32'd0;
        mem_size       = 3'd0;
        if_rvalid      = 1'b0;
        if_rdata       = 32'd0;
        d_rvalid       = 1'b0;
        d_rdata        = 32'd0;

        if (r_state == BUSY) begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (w_resp) begin
                w_state_nxt = IDLE;
            end
        end

        if (w_resp) begin
            if (r_owner == OWN_FETCH) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end else begin
                d_rvalid = 1'b1;
                d_rdata  = r_is_store ? 32'd0 : mem_rdata;
            end
        end

        if (w_pick_d) begin
            mem_en         = 1'b1;
            mem_we         = d_we;
            mem_addr       = d_addr;
            mem_wdata      = d_wdata;
            mem_size       = d_size;
            w_state_nxt    = BUSY;
            w_cnt_nxt      = LAT4;
            w_owner_nxt    = OWN_DATA;
            w_is_store_nxt = d_we;
            if (if_req) begin
                w_streak_nxt = (r_streak == STARVE4) ? r_streak : r_streak + 4'd1;
            end else begin
                w_streak_nxt = 4'd0;
            end
        end else if (w_pick_f) begin
            mem_en         = 1'b1;
            mem_addr       = if_addr;
            mem_size       = 3'b010;
            w_state_nxt    = BUSY;
            w_cnt_nxt      = LAT4;
            w_owner_nxt    = OWN_FETCH;
            w_is_store_nxt = 1'b0;
            w_streak_nxt   = 4'd0;
        end
    end
endmodule
